// File: rtl/img_stream_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_stream_source_pkg
//  Description : Shared FSM encoding, register map and STATUS bit positions
//                for the image stream source.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_stream_source_pkg;

  // Streaming controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_PIXEL  = 2'd2;
  localparam logic [1:0] ADDR_WPTR   = 2'd3;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ERR_BIT   = 2;

  // Pixel index width; a one-pixel image still needs a one-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_stream_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : img_stream_source_if
//  Description : Avalon-MM control slave and Avalon-ST pixel source signals.
//                'slave' is the block side, 'master' the host/sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface img_stream_source_if;

  logic [1:0]  avs_s1_address;
  logic        avs_s1_write;
  logic [31:0] avs_s1_writedata;
  logic        avs_s1_read;
  logic [31:0] avs_s1_readdata;

  logic        aso_source1_ready;
  logic [7:0]  aso_source1_data;
  logic        aso_source1_startofpacket;
  logic        aso_source1_endofpacket;
  logic        aso_source1_valid;

  modport slave (
    input  avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
    output avs_s1_readdata,
    input  aso_source1_ready,
    output aso_source1_data, aso_source1_startofpacket,
    output aso_source1_endofpacket, aso_source1_valid
  );

  modport master (
    output avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
    input  avs_s1_readdata,
    output aso_source1_ready,
    input  aso_source1_data, aso_source1_startofpacket,
    input  aso_source1_endofpacket, aso_source1_valid
  );

endinterface
`default_nettype wire

// File: rtl/img_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : img_buf_ram
//  Description : Simple dual-port 8-bit pixel RAM, one write port, one read
//                port with a single registered read stage (block-RAM style).
//  Revision    : 1.0 - initial release
// ============================================================================
module img_buf_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wire logic          clk_i,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [7:0]    wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic [7:0]         rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write port; storage has no reset so contents survive a block reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, reads every cycle
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/img_stream_source.sv
`default_nettype none
// ============================================================================
//  Module      : img_stream_source
//  Description : Pixel buffer loaded over Avalon-MM, sent as one Avalon-ST
//                packet per start command with one-beat-per-cycle prefetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_stream_source
  import img_stream_source_pkg::*;
#(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100
) (
  input  wire logic           csi_clkrst_clk,
  input  wire logic           csi_clkrst_reset,
  img_stream_source_if.slave  bus
);

  localparam int              N        = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int              AW       = idx_width(N);
  localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);
  localparam logic [31:0]     N_W      = 32'(N);

  state_e          state_q;
  logic [AW-1:0]   rptr_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic            valid_q, sop_q, eop_q;
  logic            done_q, err_q;
  logic [31:0]     readdata_q;
  logic [31:0]     status_word;
  logic [AW-1:0]   ram_raddr;
  logic [7:0]      ram_rdata;

  logic busy, xfer, eop_xfer;
  logic wr_ctrl, wr_status, wr_pixel, wr_wptr;
  logic start_req, start_ok, ram_we, wr_err;

  assign busy      = (state_q != ST_IDLE);
  assign xfer      = valid_q & bus.aso_source1_ready;
  assign eop_xfer  = xfer & eop_q;

  assign wr_ctrl   = bus.avs_s1_write && (bus.avs_s1_address == ADDR_CTRL);
  assign wr_status = bus.avs_s1_write && (bus.avs_s1_address == ADDR_STATUS);
  assign wr_pixel  = bus.avs_s1_write && (bus.avs_s1_address == ADDR_PIXEL);
  assign wr_wptr   = bus.avs_s1_write && (bus.avs_s1_address == ADDR_WPTR);

  assign start_req = wr_ctrl & bus.avs_s1_writedata[CTRL_START_BIT];
  assign start_ok  = start_req & ~busy;
  // Buffer-modifying commands are refused while a packet is in flight
  assign ram_we    = wr_pixel & ~busy;
  assign wr_err    = busy & (start_req | wr_pixel | wr_wptr);

  // Write pointer: post-increment with wrap on PIXEL, load modulo N on WPTR
  always_comb begin
    wptr_d = wptr_q;
    if (!busy) begin
      if (wr_pixel) begin
        wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1);
      end else if (wr_wptr) begin
        wptr_d = AW'(bus.avs_s1_writedata % N_W);
      end
    end
  end

  // Read address: pixel 0 while idle/fetching, then the displayed pixel while
  // stalled or the next one on a transfer so the RAM output stays one ahead
  always_comb begin
    ram_raddr = '0;
    if (state_q == ST_STREAM) begin
      ram_raddr = (xfer && !eop_q) ? rptr_q + AW'(1) : rptr_q;
    end
  end

  img_buf_ram #(
    .DEPTH (N),
    .AW    (AW)
  ) u_buf (
    .clk_i   (csi_clkrst_clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.avs_s1_writedata[7:0]),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Streaming FSM with registered valid / startofpacket / endofpacket
  always_ff @(posedge csi_clkrst_clk) begin
    if (csi_clkrst_reset) begin
      state_q <= ST_IDLE;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rptr_q <= '0;
          if (start_ok) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_q <= ST_STREAM;
          rptr_q  <= '0;
          valid_q <= 1'b1;
          sop_q   <= 1'b1;
          eop_q   <= (LAST_IDX == '0);
        end
        ST_STREAM: begin
          if (xfer) begin
            if (eop_q) begin
              state_q <= ST_IDLE;
              rptr_q  <= '0;
              valid_q <= 1'b0;
              sop_q   <= 1'b0;
              eop_q   <= 1'b0;
            end else begin
              rptr_q  <= rptr_q + AW'(1);
              sop_q   <= 1'b0;
              eop_q   <= ((rptr_q + AW'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY_BIT] = busy;
    status_word[STAT_DONE_BIT] = done_q;
    status_word[STAT_ERR_BIT]  = err_q;
  end

  // Register file: write pointer, sticky flags and registered read data
  always_ff @(posedge csi_clkrst_clk) begin
    if (csi_clkrst_reset) begin
      wptr_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      if (wr_status && bus.avs_s1_writedata[STAT_ERR_BIT]) begin
        err_q <= 1'b0;
      end
      if (wr_err) begin
        err_q <= 1'b1;
      end
      // A completing packet wins over a same-cycle clear so it is not lost
      if (wr_status && bus.avs_s1_writedata[STAT_DONE_BIT]) begin
        done_q <= 1'b0;
      end
      if (eop_xfer) begin
        done_q <= 1'b1;
      end
      if (bus.avs_s1_read) begin
        case (bus.avs_s1_address)
          ADDR_STATUS: readdata_q <= status_word;
          ADDR_WPTR:   readdata_q <= 32'(wptr_q);
          default:     readdata_q <= '0;
        endcase
      end else begin
        readdata_q <= '0;
      end
    end
  end

  assign bus.avs_s1_readdata           = readdata_q;
  assign bus.aso_source1_valid         = valid_q;
  assign bus.aso_source1_startofpacket = sop_q;
  assign bus.aso_source1_endofpacket   = eop_q;
  // RAM output is only meaningful while a beat is presented
  assign bus.aso_source1_data          = valid_q ? ram_rdata : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_img_stream_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_stream_source
//  Description : Self-checking bench for img_stream_source (4x2 and 1x1
//                images) against a register/buffer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_stream_source;
  import img_stream_source_pkg::*;

  localparam int XS   = 4;
  localparam int YS   = 2;
  localparam int NPIX = XS * YS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_stream_source_if bus ();
  img_stream_source_if bus1 ();

  img_stream_source #(.IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
    .csi_clkrst_clk   (clk),
    .csi_clkrst_reset (rst),
    .bus              (bus)
  );

  img_stream_source #(.IMG_X_SIZE(1), .IMG_Y_SIZE(1)) dut1 (
    .csi_clkrst_clk   (clk),
    .csi_clkrst_reset (rst),
    .bus              (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: image buffer, write pointer, sticky flags
  logic [7:0] m_mem [NPIX];
  int         m_wptr = 0;
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d, input bit busy);
    case (a)
      ADDR_CTRL:   if (d[0] && busy) m_err = 1'b1;
      ADDR_STATUS: begin
        if (d[2]) m_err  = 1'b0;
        if (d[1]) m_done = 1'b0;
      end
      ADDR_PIXEL:  if (busy) m_err = 1'b1;
                   else begin
                     m_mem[m_wptr] = d[7:0];
                     m_wptr = (m_wptr + 1) % NPIX;
                   end
      default:     if (busy) m_err = 1'b1;
                   else m_wptr = int'(d % 32'(NPIX));
    endcase
  endfunction

  task automatic mm_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_s1_address   = a;
    bus.avs_s1_writedata = d;
    bus.avs_s1_write     = 1'b1;
    tick();
    bus.avs_s1_write     = 1'b0;
    model_write(a, d, 1'b0);
  endtask

  task automatic mm_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_s1_address = a;
    bus.avs_s1_read    = 1'b1;
    tick();
    bus.avs_s1_read    = 1'b0;
    d = bus.avs_s1_readdata;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    mm_rd(ADDR_STATUS, d);
    chk(tag, d, {29'b0, m_err, m_done, 1'b0});
  endtask

  task automatic chk_wptr(input string tag);
    logic [31:0] d;
    mm_rd(ADDR_WPTR, d);
    chk(tag, d, 32'(m_wptr));
  endtask

  task automatic load_ramp();
    mm_wr(ADDR_WPTR, 32'd0);
    for (int i = 0; i < NPIX; i++) mm_wr(ADDR_PIXEL, 32'h10 + 32'(i));
  endtask

  // mode 0: ready always 1, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic run_pkt(input int mode, input bit inject);
    int k;
    int cyc;
    bit rdy;
    bus.aso_source1_ready = 1'b1;
    bus.avs_s1_address    = ADDR_CTRL;
    bus.avs_s1_writedata  = 32'd1;
    bus.avs_s1_write      = 1'b1;
    tick();
    bus.avs_s1_write = 1'b0;
    chk("lat_t1_valid", 32'(bus.aso_source1_valid), 32'd0);
    tick();
    chk("lat_t2_valid", 32'(bus.aso_source1_valid), 32'd1);
    k   = 0;
    cyc = 0;
    while (k < NPIX && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.aso_source1_ready = rdy;
      if (inject && cyc == 2) begin
        bus.avs_s1_address = ADDR_CTRL;  bus.avs_s1_writedata = 32'd1;  bus.avs_s1_write = 1'b1;
        model_write(ADDR_CTRL, 32'd1, 1'b1);
      end
      if (inject && cyc == 4) begin
        bus.avs_s1_address = ADDR_PIXEL; bus.avs_s1_writedata = 32'h5A; bus.avs_s1_write = 1'b1;
        model_write(ADDR_PIXEL, 32'h5A, 1'b1);
      end
      chk("beat_valid", 32'(bus.aso_source1_valid), 32'd1);
      if (!bus.aso_source1_valid) break;
      chk("beat", {22'b0, bus.aso_source1_data, bus.aso_source1_startofpacket,
                   bus.aso_source1_endofpacket},
          {22'b0, m_mem[k], k == 0, k == NPIX - 1});
      if (rdy) k++;
      tick();
      bus.avs_s1_write = 1'b0;
      cyc++;
    end
    bus.avs_s1_write = 1'b0;
    chk("pkt_beats", 32'(k), 32'(NPIX));
    m_done = 1'b1;
    chk("post_eop_valid", 32'(bus.aso_source1_valid), 32'd0);
    bus.aso_source1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt;
    bus.avs_s1_address = '0;  bus.avs_s1_write = 1'b0; bus.avs_s1_writedata = '0;
    bus.avs_s1_read = 1'b0;   bus.aso_source1_ready = 1'b0;
    bus1.avs_s1_address = '0; bus1.avs_s1_write = 1'b0; bus1.avs_s1_writedata = '0;
    bus1.avs_s1_read = 1'b0;  bus1.aso_source1_ready = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_outputs", {bus.aso_source1_valid, bus.aso_source1_startofpacket,
                        bus.aso_source1_endofpacket, 29'(bus.aso_source1_data)}, 32'd0);
    chk("rst_readdata", bus.avs_s1_readdata, 32'd0);
    rst = 1'b0;
    tick();
    chk_status("rst_status");
    chk_wptr("rst_wptr");

    // 4x2 ramp image, ready held high
    load_ramp();
    chk_wptr("ramp_wptr_wrap");
    mm_rd(ADDR_CTRL, d);
    chk("ctrl_read", d, 32'd0);
    run_pkt(0, 1'b0);
    chk_status("ramp_done");

    // Same image with ready toggling 1,0,0,1
    run_pkt(1, 1'b0);
    chk_status("toggle_done");

    // Start and PIXEL writes while busy are rejected and flag err
    run_pkt(0, 1'b1);
    chk_status("busy_err");
    chk_wptr("busy_wptr_kept");
    mm_wr(ADDR_STATUS, 32'h4);
    chk_status("err_clear");
    mm_wr(ADDR_STATUS, 32'h2);
    chk_status("done_clear");

    // Simultaneous read and write: read returns the pre-write pointer
    bus.avs_s1_address = ADDR_WPTR; bus.avs_s1_writedata = 32'd3;
    bus.avs_s1_write = 1'b1;        bus.avs_s1_read = 1'b1;
    tick();
    bus.avs_s1_write = 1'b0;        bus.avs_s1_read = 1'b0;
    chk("rw_same_cycle", bus.avs_s1_readdata, 32'(m_wptr));
    model_write(ADDR_WPTR, 32'd3, 1'b0);
    chk_wptr("rw_wptr_new");

    // WPTR load is taken modulo N
    mm_wr(ADDR_WPTR, 32'hFFFF_FFFD);
    chk_wptr("wptr_modulo");

    // PIXEL write wrap from the last pixel back to 0
    mm_wr(ADDR_WPTR, 32'd7);
    mm_wr(ADDR_PIXEL, 32'hEE);
    mm_wr(ADDR_PIXEL, 32'hFF);
    chk_wptr("wrap_wptr");
    run_pkt(0, 1'b0);

    // Reset on the third beat of a packet
    load_ramp();
    bus.aso_source1_ready = 1'b1;
    bus.avs_s1_address = ADDR_CTRL; bus.avs_s1_writedata = 32'd1; bus.avs_s1_write = 1'b1;
    tick();
    bus.avs_s1_write = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid_beat3", {24'b0, bus.aso_source1_data}, {24'b0, m_mem[2]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid_eop", {bus.aso_source1_valid, bus.aso_source1_endofpacket}, 2'b00);
    bus.aso_source1_ready = 1'b0;
    m_wptr = 0; m_done = 1'b0; m_err = 1'b0;
    chk_status("rst_mid_status");
    run_pkt(0, 1'b0);

    // Randomized images and ready patterns
    for (int it = 0; it < 4; it++) begin
      mm_wr(ADDR_WPTR, $urandom);
      cnt = $urandom_range(1, 12);
      for (int j = 0; j < cnt; j++) mm_wr(ADDR_PIXEL, 32'($urandom_range(0, 255)));
      chk_wptr("rand_wptr");
      run_pkt(2, 1'b0);
      chk_status("rand_status");
    end

    // 1x1 image: single beat carrying both SOP and EOP
    bus1.avs_s1_address = ADDR_PIXEL; bus1.avs_s1_writedata = 32'hAB; bus1.avs_s1_write = 1'b1;
    tick();
    bus1.avs_s1_write = 1'b0;
    bus1.avs_s1_address = ADDR_WPTR; bus1.avs_s1_read = 1'b1;
    tick();
    bus1.avs_s1_read = 1'b0;
    chk("n1_wptr_wrap", bus1.avs_s1_readdata, 32'd0);
    bus1.aso_source1_ready = 1'b1;
    bus1.avs_s1_address = ADDR_CTRL; bus1.avs_s1_writedata = 32'd1; bus1.avs_s1_write = 1'b1;
    tick();
    bus1.avs_s1_write = 1'b0;
    chk("n1_t1_valid", 32'(bus1.aso_source1_valid), 32'd0);
    tick();
    chk("n1_beat", {21'b0, bus1.aso_source1_valid, bus1.aso_source1_data,
                    bus1.aso_source1_startofpacket, bus1.aso_source1_endofpacket},
        {21'b0, 1'b1, 8'hAB, 1'b1, 1'b1});
    tick();
    chk("n1_post_valid", 32'(bus1.aso_source1_valid), 32'd0);
    bus1.avs_s1_address = ADDR_STATUS; bus1.avs_s1_read = 1'b1;
    tick();
    bus1.avs_s1_read = 1'b0;
    chk("n1_status", bus1.avs_s1_readdata, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/img_stream_source.md
IMG_STREAM_SOURCE -- requirements
Module: img_stream_source

Interface
REQ-001 Parameter IMG_X_SIZE, default 100: pixels per image row.
REQ-002 Parameter IMG_Y_SIZE, default 100: rows per image; N = IMG_X_SIZE*IMG_Y_SIZE pixels per packet.
REQ-003 csi_clkrst_clk  in  1  sole clock; all logic on rising edge.
REQ-004 csi_clkrst_reset  in  1  synchronous, active-high reset.
REQ-005 avs_s1_address  in  2  register select: 0 CTRL, 1 STATUS, 2 PIXEL, 3 WPTR.
REQ-006 avs_s1_write  in  1  write strobe, one register write per asserted cycle.
REQ-007 avs_s1_writedata  in  32  write data.
REQ-008 avs_s1_read  in  1  read strobe.
REQ-009 avs_s1_readdata  out  32  read data, valid the cycle after avs_s1_read.
REQ-010 aso_source1_ready  in  1  downstream ready, readyLatency 0.
REQ-011 aso_source1_data  out  8  grayscale pixel.
REQ-012 aso_source1_startofpacket  out  1  first pixel of the image.
REQ-013 aso_source1_endofpacket  out  1  last pixel of the image.
REQ-014 aso_source1_valid  out  1  beat valid.

Function
REQ-015 Block SHALL hold an N x 8-bit pixel buffer, loaded over Avalon-MM and streamed as one Avalon-ST packet per start command.
REQ-016 Write to PIXEL SHALL store writedata[7:0] at wptr, then set wptr to wptr+1, wrapping N-1 -> 0.
REQ-017 Write to WPTR SHALL set wptr to writedata modulo N; read of WPTR SHALL return wptr zero-extended.
REQ-018 Write to CTRL with writedata[0]=1 in IDLE SHALL start streaming; CTRL reads return 0.
REQ-019 STATUS read SHALL return {29'b0, err, done, busy}; writing STATUS with writedata[2]=1 SHALL clear err, with writedata[1]=1 SHALL clear done.
REQ-020 FSM states: IDLE (busy=0), FETCH (busy=1, buffer read of pixel 0 issued), STREAM (busy=1, valid=1); no other states.
REQ-021 IDLE -> FETCH on accepted start; FETCH -> STREAM after exactly one cycle; STREAM -> IDLE on the cycle the beat with endofpacket transfers.
REQ-022 Start write in cycle T SHALL give aso_source1_valid=1 first in cycle T+2.
REQ-023 Beat transfers when valid && ready; while valid=1 and ready=0, data, startofpacket and endofpacket SHALL hold stable.
REQ-024 Pixel index rptr SHALL run 0..N-1; startofpacket=1 only for rptr=0; endofpacket=1 only for rptr=N-1; both asserted on the same beat when N=1.
REQ-025 Back-to-back transfers at one pixel per cycle SHALL be sustained while ready=1 (buffer prefetch of rptr+1, no bubbles).
REQ-026 done SHALL set on the EOP transfer and remain set until cleared or reset.
REQ-027 Start, PIXEL or WPTR writes while busy=1 SHALL be ignored with no side effect and SHALL set err; STATUS clear writes are always honoured.
REQ-028 Simultaneous read and write in one cycle: write SHALL take effect; readdata SHALL reflect pre-write state.
REQ-029 Buffer contents SHALL be unchanged by streaming; repeated starts re-send the same image.

Reset
REQ-030 On reset: state IDLE, wptr=0, rptr=0, busy=0, done=0, err=0, avs_s1_readdata=0, aso_source1_valid=0, startofpacket=0, endofpacket=0, aso_source1_data=0.
REQ-031 Reset mid-packet SHALL drop valid on the next cycle without emitting endofpacket; buffer contents are not cleared.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, register address constants (CTRL=0, STATUS=1, PIXEL=2, WPTR=3) and STATUS bit positions.
REQ-033 Pixel storage SHALL be sub-module img_buf_ram: single clock, one write port, one read port, one-cycle registered read latency, inferable as block RAM.
REQ-034 Index widths SHALL be $clog2(N), minimum 1.

Verification
REQ-035 IMG 4x2: write pixels 0x10..0x17, start, ready=1 -> 8 consecutive beats 0x10..0x17, SOP on 0x10, EOP on 0x17, valid first at T+2, done=1.
REQ-036 Same image, ready toggled 1,0,0,1 repeating -> identical data sequence, outputs stable during ready=0, no lost or duplicated beat.
REQ-037 Start while busy, and PIXEL write while busy -> packet unaffected, err=1; STATUS write 0x4 -> err=0.
REQ-038 IMG 1x1, pixel 0xAB, start -> single beat 0xAB with SOP=EOP=1.
REQ-039 Reset asserted at 3rd beat of 4x2 packet -> valid=0 next cycle, no EOP, STATUS=0; restart -> full packet 0x10..0x17.
REQ-040 WPTR write 7, two PIXEL writes 0xEE,0xFF on 4x2 -> pixel7=0xEE, pixel0=0xFF (wrap), WPTR reads 1.
